// File: rtl/vscale_md_pkg.sv
// Shared encodings for the mul_div front end: opcodes, output selects,
// RV32M funct3 values and the issue-controller state enum.
package vscale_md_pkg;

  localparam int MD_OP_WIDTH      = 2;
  localparam int MD_OUT_SEL_WIDTH = 2;

  localparam logic [MD_OP_WIDTH-1:0] OP_MUL = 2'd0;
  localparam logic [MD_OP_WIDTH-1:0] OP_DIV = 2'd1;
  localparam logic [MD_OP_WIDTH-1:0] OP_REM = 2'd2;

  localparam logic [MD_OUT_SEL_WIDTH-1:0] OUT_LO  = 2'd0;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] OUT_HI  = 2'd1;
  localparam logic [MD_OUT_SEL_WIDTH-1:0] OUT_REM = 2'd2;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } md_state_e;

endpackage

// File: rtl/vscale_md_decode.sv
// Combinational RV32M funct3 decoder producing the mul_div request fields.
module vscale_md_decode
  import vscale_md_pkg::*;
(
  input  logic [2:0]                  funct3_i,
  output logic [MD_OP_WIDTH-1:0]      op_o,
  output logic [MD_OUT_SEL_WIDTH-1:0] out_sel_o,
  output logic                        in_1_signed_o,
  output logic                        in_2_signed_o,
  output logic                        is_div_o
);

  always_comb begin
    op_o          = OP_MUL;
    out_sel_o     = OUT_LO;
    in_1_signed_o = 1'b1;
    in_2_signed_o = 1'b1;
    is_div_o      = funct3_i[2];
    unique case (funct3_i)
      F3_MUL:    ;
      F3_MULH:   out_sel_o = OUT_HI;
      F3_MULHSU: begin
        out_sel_o     = OUT_HI;
        in_2_signed_o = 1'b0;
      end
      F3_MULHU: begin
        out_sel_o     = OUT_HI;
        in_1_signed_o = 1'b0;
        in_2_signed_o = 1'b0;
      end
      F3_DIV:    op_o = OP_DIV;
      F3_DIVU: begin
        op_o          = OP_DIV;
        in_1_signed_o = 1'b0;
        in_2_signed_o = 1'b0;
      end
      F3_REM: begin
        op_o      = OP_REM;
        out_sel_o = OUT_REM;
      end
      F3_REMU: begin
        op_o          = OP_REM;
        out_sel_o     = OUT_REM;
        in_1_signed_o = 1'b0;
        in_2_signed_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vscale_md_issue_ctrl.sv
// Pipeline front end for vscale_mul_div: holds one RV32M op, issues it, waits for
// the result and offers it on writeback. MD_DIV_SPECIAL_FAST_EN resolves div-by-zero/overflow locally.
module vscale_md_issue_ctrl
  import vscale_md_pkg::*;
#(
  parameter int XPR_LEN        = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_funct3,
  input  logic [XPR_LEN-1:0]          cmd_rs1,
  input  logic [XPR_LEN-1:0]          cmd_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]   cmd_rd,
  input  logic                        kill,
  output logic                        md_req_valid,
  input  logic                        md_req_ready,
  output logic [MD_OP_WIDTH-1:0]      md_req_op,
  output logic [MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic                        md_req_in_1_signed,
  output logic                        md_req_in_2_signed,
  output logic [XPR_LEN-1:0]          md_req_in_1,
  output logic [XPR_LEN-1:0]          md_req_in_2,
  input  logic                        md_resp_valid,
  input  logic [XPR_LEN-1:0]          md_resp_result,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]   wb_rd,
  output logic [XPR_LEN-1:0]          wb_data,
  output logic                        busy
);

  md_state_e                   state_q, state_d;
  logic [MD_OP_WIDTH-1:0]      op_q, op_d;
  logic [MD_OUT_SEL_WIDTH-1:0] out_sel_q, out_sel_d;
  logic                        in_1_signed_q, in_1_signed_d;
  logic                        in_2_signed_q, in_2_signed_d;
  logic [XPR_LEN-1:0]          in_1_q, in_1_d;
  logic [XPR_LEN-1:0]          in_2_q, in_2_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic [XPR_LEN-1:0]          wb_data_q, wb_data_d;

  logic [MD_OP_WIDTH-1:0]      dec_op;
  logic [MD_OUT_SEL_WIDTH-1:0] dec_out_sel;
  logic                        dec_in_1_signed;
  logic                        dec_in_2_signed;
  logic                        dec_is_div;

  vscale_md_decode u_decode (
    .funct3_i      (cmd_funct3),
    .op_o          (dec_op),
    .out_sel_o     (dec_out_sel),
    .in_1_signed_o (dec_in_1_signed),
    .in_2_signed_o (dec_in_2_signed),
    .is_div_o      (dec_is_div)
  );

`ifdef MD_DIV_SPECIAL_FAST_EN
  // Divide-by-zero and signed overflow have fixed RISC-V answers, so they bypass mul_div.
  localparam logic [XPR_LEN-1:0] MIN_NEG = {1'b1, {(XPR_LEN-1){1'b0}}};
  logic               fast_rs2_zero;
  logic               fast_ovf;
  logic               fast_hit;
  logic [XPR_LEN-1:0] fast_result;

  always_comb begin
    fast_rs2_zero = (cmd_rs2 == '0);
    fast_ovf      = dec_in_1_signed && (cmd_rs1 == MIN_NEG) && (cmd_rs2 == '1);
    fast_hit      = dec_is_div && (fast_rs2_zero || fast_ovf);
    if (fast_rs2_zero) fast_result = (dec_op == OP_DIV) ? '1 : cmd_rs1;
    else               fast_result = (dec_op == OP_DIV) ? MIN_NEG : '0;
  end
`endif

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    out_sel_d     = out_sel_q;
    in_1_signed_d = in_1_signed_q;
    in_2_signed_d = in_2_signed_q;
    in_1_d        = in_1_q;
    in_2_d        = in_2_q;
    rd_d          = rd_q;
    wb_data_d     = wb_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d          = dec_op;
          out_sel_d     = dec_out_sel;
          in_1_signed_d = dec_in_1_signed;
          in_2_signed_d = dec_in_2_signed;
          in_1_d        = cmd_rs1;
          in_2_d        = cmd_rs2;
          rd_d          = cmd_rd;
          state_d       = S_ISSUE;
`ifdef MD_DIV_SPECIAL_FAST_EN
          if (fast_hit) begin
            wb_data_d = fast_result;
            state_d   = S_DONE;
          end
`endif
        end
      end
      // Once mul_div has taken the request it cannot be recalled, so a late kill must drain.
      S_ISSUE: begin
        if (md_req_ready) state_d = kill ? S_DRAIN : S_WAIT;
        else if (kill)    state_d = S_IDLE;
      end
      S_WAIT: begin
        if (kill) begin
          state_d = md_resp_valid ? S_IDLE : S_DRAIN;
        end else if (md_resp_valid) begin
          wb_data_d = md_resp_result;
          state_d   = S_DONE;
        end
      end
      S_DRAIN: begin
        if (md_resp_valid) state_d = S_IDLE;
      end
      S_DONE: begin
        if (kill || wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      out_sel_q     <= '0;
      in_1_signed_q <= 1'b0;
      in_2_signed_q <= 1'b0;
      in_1_q        <= '0;
      in_2_q        <= '0;
      rd_q          <= '0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      out_sel_q     <= out_sel_d;
      in_1_signed_q <= in_1_signed_d;
      in_2_signed_q <= in_2_signed_d;
      in_1_q        <= in_1_d;
      in_2_q        <= in_2_d;
      rd_q          <= rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign busy               = (state_q != S_IDLE);
  assign md_req_valid       = (state_q == S_ISSUE);
  assign wb_valid           = (state_q == S_DONE);
  assign md_req_op          = op_q;
  assign md_req_out_sel     = out_sel_q;
  assign md_req_in_1_signed = in_1_signed_q;
  assign md_req_in_2_signed = in_2_signed_q;
  assign md_req_in_1        = in_1_q;
  assign md_req_in_2        = in_2_q;
  assign wb_rd              = rd_q;
  assign wb_data            = wb_data_q;

  // A response with nothing in flight means the mul_div handshake is out of step.
  assert property (@(posedge clk) disable iff (reset)
    md_resp_valid |-> (state_q == S_WAIT || state_q == S_DRAIN));

  assert property (@(posedge clk) disable iff (reset)
    dec_is_div == (dec_op != OP_MUL));

endmodule

// File: doc/vscale_md_issue_ctrl.md
Name: vscale_md_issue_ctrl

Overview:
- Pipeline-side front end for the vscale_mul_div unit.
- Accepts one decoded RV32M instruction (funct3, rs1, rs2, rd), translates it into an mul_div request, and holds it until mul_div accepts it.
- Waits for the variable-latency response and presents the result on a writeback handshake.
- Supports pipeline kill, which drops or drains the in-flight operation.

Parameters:
- XPR_LEN, 32, operand/result width.
- REG_ADDR_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  instruction offered
- cmd_ready  out  1  controller can accept
- cmd_funct3  in  3  RV32M funct3
- cmd_rs1  in  XPR_LEN  operand 1
- cmd_rs2  in  XPR_LEN  operand 2
- cmd_rd  in  REG_ADDR_WIDTH  destination register
- kill  in  1  flush current instruction
- md_req_valid  out  1  to mul_div req_valid
- md_req_ready  in  1  from mul_div req_ready
- md_req_op  out  MD_OP_WIDTH  opcode
- md_req_out_sel  out  MD_OUT_SEL_WIDTH  output select
- md_req_in_1_signed  out  1  operand 1 signedness
- md_req_in_2_signed  out  1  operand 2 signedness
- md_req_in_1  out  XPR_LEN  operand 1
- md_req_in_2  out  XPR_LEN  operand 2
- md_resp_valid  in  1  mul_div result valid
- md_resp_result  in  XPR_LEN  mul_div result
- wb_valid  out  1  result available
- wb_ready  in  1  writeback consumes
- wb_rd  out  REG_ADDR_WIDTH  destination register
- wb_data  out  XPR_LEN  result
- busy  out  1  state != S_IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; every flop clears on reset assertion, independent of clk.
- Reset values: state=S_IDLE, md_req_valid=0, wb_valid=0, busy=0, wb_data=0, wb_rd=0, all md_req_* fields 0.
- States (3-bit): S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN.
- S_IDLE:
  - cmd_ready=1.
  - On cmd_valid, register the decoded fields, rs1/rs2 and rd, then go to S_ISSUE.
  - kill in S_IDLE is ignored, and a cmd in the same cycle is still accepted. Kill applies only to the held instruction.
- Decode from funct3:
  - 0 MUL: OP_MUL, OUT_LO, s/s.
  - 1 MULH: OP_MUL, OUT_HI, s/s.
  - 2 MULHSU: OP_MUL, OUT_HI, s/u.
  - 3 MULHU: OP_MUL, OUT_HI, u/u.
  - 4 DIV: OP_DIV, OUT_LO, s/s.
  - 5 DIVU: OP_DIV, OUT_LO, u/u.
  - 6 REM: OP_REM, OUT_REM, s/s.
  - 7 REMU: OP_REM, OUT_REM, u/u.
- S_ISSUE:
  - md_req_valid=1, with the md_req_* fields driven from registers and stable until accepted.
  - md_req_valid & md_req_ready moves to S_WAIT.
  - kill with md_req_ready=0 goes to S_IDLE and nothing is issued.
  - kill with md_req_ready=1 in the same cycle: the request was accepted, so go to S_DRAIN.
- S_WAIT:
  - md_resp_valid latches md_resp_result into wb_data and goes to S_DONE.
  - kill goes to S_DRAIN; if md_resp_valid arrives in the same cycle, discard the result and go to S_IDLE.
- S_DRAIN:
  - mul_div cannot abort, so wait for md_resp_valid, discard the result, then go to S_IDLE.
  - cmd_ready=0 throughout.
- S_DONE:
  - wb_valid=1; wb_data and wb_rd are held.
  - wb_valid & wb_ready goes to S_IDLE. There is no same-cycle new accept; cmd_ready is a pure state decode.
  - kill goes to S_IDLE, and wb_valid falls next cycle.
- Latency:
  - Accept to md_req_valid: 1 cycle.
  - mul_div takes 34 cycles from accept to resp_valid.
  - Capture to wb_valid: 1 cycle.
- md_resp_valid outside S_WAIT/S_DRAIN is ignored. It is flagged by an assertion.

Optional Feature:
- Macro: MD_DIV_SPECIAL_FAST_EN.
- Defined: in S_IDLE, for funct3 4-7 the controller skips mul_div when either special case below holds. It goes straight to S_DONE in 1 cycle with the RISC-V result:
  - rs2==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - Signed overflow (rs1==0x80000000, rs2==0xFFFFFFFF, funct3 4/6): DIV gives 0x80000000; REM gives 0.
- Undefined: all operations are issued to mul_div.
- Architectural wb_data must be identical in both builds.

Decomposition:
- Shared package vscale_md_pkg holds:
  - MD_OP_WIDTH=2, OP_MUL=0, OP_DIV=1, OP_REM=2.
  - MD_OUT_SEL_WIDTH=2, OUT_LO=0, OUT_HI=1, OUT_REM=2.
  - The funct3 encodings and the state enum.
- One sub-module: vscale_md_decode, a combinational funct3 -> {op, out_sel, in_1_signed, in_2_signed, is_div}.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), funct3=0 -> md_req_op=MUL, OUT_LO, s/s; wb_data=0xFFFFFFEB, wb_rd held, wb_valid 1 cycle after md_resp_valid.
- MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> wb_data=0xFFFFFFFE; MULHSU: -1 x 2 -> 0xFFFFFFFF.
- DIV/REM: -20 / 6 -> DIV gives 0xFFFFFFFD; REM gives 0xFFFFFFFE. Hold md_req_ready=0 for 5 cycles; md_req_* must stay stable.
- Kill in S_ISSUE (md_req_ready=0) -> no request issued, back to S_IDLE. Kill 10 cycles into S_WAIT -> S_DRAIN; the response is discarded, wb_valid never rises, and cmd_ready returns after md_resp_valid.
- Backpressure: wb_ready=0 for 8 cycles -> wb_valid, wb_data and cmd_ready=0 hold. Assert reset mid-S_WAIT -> all outputs zero immediately, without waiting for a clk edge.
- DIVU by 0 with rs1=0x1234 -> 0xFFFFFFFF; REM of 0x80000000 by -1 -> 0. With MD_DIV_SPECIAL_FAST_EN, md_req_valid is never asserted and wb_valid comes 1 cycle after accept.
